// File: rtl/wb_stage_if.sv
// MEM/WB-to-writeback bus.
// master: the MEM/WB pipeline register side. It drives the instruction fields and observes the
//         register-file write port, the forward record, the halt flag and the retire count.
// slave : the writeback stage. It consumes the instruction fields and drives the write port,
//         the forward record, the halt flag and the retire count.
interface wb_stage_if;
  // MEM/WB pipeline register outputs
  logic        WEN_MEM_WB;
  logic [1:0]  reg_dest_MEM_WB;
  logic [4:0]  Rt_MEM_WB;
  logic [4:0]  Rd_MEM_WB;
  logic [1:0]  mem_to_reg_MEM_WB;
  logic [31:0] result_MEM_WB;
  logic [31:0] mem_data_MEM_WB;
  logic [31:0] next_imemaddr_MEM_WB;
  logic [15:0] imm16_MEM_WB;
  logic [31:0] instruction_MEM_WB;
  logic        halt;

  // Register-file write port (combinational)
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;

  // Late-forwarding record and status (registered)
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        halted;
  logic [31:0] retired;

  modport master (
    output WEN_MEM_WB, reg_dest_MEM_WB, Rt_MEM_WB, Rd_MEM_WB, mem_to_reg_MEM_WB,
           result_MEM_WB, mem_data_MEM_WB, next_imemaddr_MEM_WB, imm16_MEM_WB,
           instruction_MEM_WB, halt,
    input  WEN, wsel, wdat, fwd_valid, fwd_reg, fwd_data, halted, retired
  );

  modport slave (
    input  WEN_MEM_WB, reg_dest_MEM_WB, Rt_MEM_WB, Rd_MEM_WB, mem_to_reg_MEM_WB,
           result_MEM_WB, mem_data_MEM_WB, next_imemaddr_MEM_WB, imm16_MEM_WB,
           instruction_MEM_WB, halt,
    output WEN, wsel, wdat, fwd_valid, fwd_reg, fwd_data, halted, retired
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage of the five-stage MIPS pipeline.
// It resolves the destination register and the write-back data from the MEM/WB register and
// drives the register-file write port. It also keeps a one-entry record of the last committed
// write for late forwarding, holds a sticky halt flag, and counts retired instructions.
// Ports:
//   CLK : pipeline clock; all state updates on the rising edge
//   RST : synchronous, active-high reset
//   wb  : wb_stage_if.slave. It carries the MEM/WB fields in, and the write port
//         (WEN/wsel/wdat), the forward record (fwd_*), halted and retired out.
module wb_stage (
  input  logic        CLK,
  input  logic        RST,
  wb_stage_if.slave   wb
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic        fwd_valid_q, fwd_valid_d;
  logic [4:0]  fwd_reg_q, fwd_reg_d;
  logic [31:0] fwd_data_q, fwd_data_d;
  logic [31:0] retired_q, retired_d;

  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic        wen;
  logic        running;

  assign running = (state_q == StRun);

  // Destination and data select
  always_comb begin
    wsel = 5'd0;
    unique case (wb.reg_dest_MEM_WB)
      2'd0:    wsel = wb.Rt_MEM_WB;
      2'd1:    wsel = wb.Rd_MEM_WB;
      2'd2:    wsel = 5'd31;
      default: wsel = 5'd0;  // reserved select; $0 is never written
    endcase

    wdat = 32'd0;
    unique case (wb.mem_to_reg_MEM_WB)
      2'd0:    wdat = wb.result_MEM_WB;
      2'd1:    wdat = wb.mem_data_MEM_WB;
      2'd2:    wdat = wb.next_imemaddr_MEM_WB;
      default: wdat = {wb.imm16_MEM_WB, 16'h0000};
    endcase
  end

  // The HALT instruction itself never writes, and nothing writes once halted or during reset.
  assign wen = wb.WEN_MEM_WB & (wsel != 5'd0) & running & ~wb.halt & ~RST;

  // Halt latch next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (wb.halt) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  // Forward record and retire counter next state
  always_comb begin
    fwd_valid_d = 1'b0;
    fwd_reg_d   = fwd_reg_q;
    fwd_data_d  = fwd_data_q;
    if (wen) begin
      fwd_valid_d = 1'b1;
      fwd_reg_d   = wsel;
      fwd_data_d  = wdat;
    end

    retired_d = retired_q;
    // Bubbles arrive as an all-zero instruction; the count saturates instead of wrapping.
    if ((wb.instruction_MEM_WB != 32'd0) && running && (retired_q != 32'hFFFF_FFFF)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StRun;
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= 5'd0;
      fwd_data_q  <= 32'd0;
      retired_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_data_q  <= fwd_data_d;
      retired_q   <= retired_d;
    end
  end

  assign wb.WEN       = wen;
  assign wb.wsel      = wsel;
  assign wb.wdat      = wdat;
  assign wb.fwd_valid = fwd_valid_q;
  assign wb.fwd_reg   = fwd_reg_q;
  assign wb.fwd_data  = fwd_data_q;
  assign wb.halted    = (state_q == StHalted);
  assign wb.retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .CLK (clk),
    .RST (rst),
    .wb  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_halted;
  logic [31:0] m_retired;
  logic        m_fv;
  logic [4:0]  m_fr;
  logic [31:0] m_fd;
  // Expected write port for the inputs currently applied
  logic        e_wen;
  logic [4:0]  e_wsel;
  logic [31:0] e_wdat;

  // Write-port behaviour taken straight from the select tables
  function automatic void model_comb();
    logic [4:0]  dests[4];
    logic [31:0] datas[4];
    dests[0] = bus.Rt_MEM_WB;
    dests[1] = bus.Rd_MEM_WB;
    dests[2] = 5'd31;
    dests[3] = 5'd0;
    datas[0] = bus.result_MEM_WB;
    datas[1] = bus.mem_data_MEM_WB;
    datas[2] = bus.next_imemaddr_MEM_WB;
    datas[3] = {16'h0000, bus.imm16_MEM_WB} * 32'd65536;
    e_wsel = dests[bus.reg_dest_MEM_WB];
    e_wdat = datas[bus.mem_to_reg_MEM_WB];
    e_wen  = bus.WEN_MEM_WB && (e_wsel != 0) && !m_halted && !bus.halt && !rst;
  endfunction

  // Effect of one rising edge on the architectural state
  function automatic void model_edge();
    if (rst) begin
      m_halted = 0; m_retired = 0; m_fv = 0; m_fr = 0; m_fd = 0;
    end else begin
      if (e_wen) begin
        m_fv = 1; m_fr = e_wsel; m_fd = e_wdat;
      end else begin
        m_fv = 0;
      end
      if (bus.instruction_MEM_WB != 0 && !m_halted && m_retired != 32'hFFFF_FFFF)
        m_retired = m_retired + 1;
      if (bus.halt) m_halted = 1;
    end
  endfunction

  task automatic drive(input logic w, input logic [1:0] rdst, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [1:0] m2r, input logic [31:0] res,
                       input logic [31:0] md, input logic [31:0] npc, input logic [15:0] imm,
                       input logic [31:0] ins, input logic h, input logic r);
    @(negedge clk);
    bus.WEN_MEM_WB           = w;
    bus.reg_dest_MEM_WB      = rdst;
    bus.Rt_MEM_WB            = rt;
    bus.Rd_MEM_WB            = rd;
    bus.mem_to_reg_MEM_WB    = m2r;
    bus.result_MEM_WB        = res;
    bus.mem_data_MEM_WB      = md;
    bus.next_imemaddr_MEM_WB = npc;
    bus.imm16_MEM_WB         = imm;
    bus.instruction_MEM_WB   = ins;
    bus.halt                 = h;
    rst                      = r;
    model_comb();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 7, 0, 32'h55, 0, 0, 0, 32'h1, 1, 1);
    total++;
    if (bus.WEN !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b want=0", bus.WEN); end
    tick();
    bubble();
    total++;
    if ({bus.fwd_valid, bus.fwd_reg, bus.fwd_data, bus.halted, bus.retired} !== '0) begin
      bad++;
      $display("FAIL reset_state got fv=%0b fr=%0d fd=%h h=%0b r=%0d want all zero",
               bus.fwd_valid, bus.fwd_reg, bus.fwd_data, bus.halted, bus.retired);
    end
  endtask

  task automatic test_alu_write();
    drive(1, 1, 3, 5, 0, 32'h1234, 32'h9, 32'h8, 16'h7, 32'h0000_1020, 0, 0);
    total++;
    if ({bus.WEN, bus.wsel, bus.wdat} !== {1'b1, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL alu_port got wen=%0b wsel=%0d wdat=%h want 1/5/1234",
               bus.WEN, bus.wsel, bus.wdat);
    end
    tick();
    bubble();
    total++;
    if ({bus.fwd_valid, bus.fwd_reg, bus.fwd_data, bus.retired}
        !== {1'b1, 5'd5, 32'h1234, 32'd1}) begin
      bad++;
      $display("FAIL alu_fwd got fv=%0b fr=%0d fd=%h ret=%0d want 1/5/1234/1",
               bus.fwd_valid, bus.fwd_reg, bus.fwd_data, bus.retired);
    end
  endtask

  task automatic test_load_lui_jal();
    drive(1, 0, 8, 9, 1, 32'h1, 32'hDEAD_BEEF, 32'h2, 16'h3, 32'h8C08_0000, 0, 0);
    total++;
    if ({bus.WEN, bus.wsel, bus.wdat} !== {1'b1, 5'd8, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL load_port got wen=%0b wsel=%0d wdat=%h want 1/8/deadbeef",
               bus.WEN, bus.wsel, bus.wdat);
    end
    tick();
    drive(1, 0, 4, 9, 3, 32'h1, 32'h2, 32'h3, 16'hABCD, 32'h3C04_ABCD, 0, 0);
    total++;
    if (bus.wdat !== 32'hABCD_0000) begin
      bad++; $display("FAIL lui_wdat got=%h want=abcd0000", bus.wdat);
    end
    tick();
    drive(1, 2, 4, 9, 2, 32'h1, 32'h2, 32'h40, 16'h5, 32'h0C00_0010, 0, 0);
    total++;
    if ({bus.WEN, bus.wsel, bus.wdat} !== {1'b1, 5'd31, 32'h40}) begin
      bad++;
      $display("FAIL jal_port got wen=%0b wsel=%0d wdat=%h want 1/31/40",
               bus.WEN, bus.wsel, bus.wdat);
    end
    tick();
    bubble();
    total++;
    if ({bus.fwd_reg, bus.fwd_data} !== {5'd31, 32'h40}) begin
      bad++; $display("FAIL jal_fwd got fr=%0d fd=%h want 31/40", bus.fwd_reg, bus.fwd_data);
    end
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 0, 6, 0, 32'h77, 0, 0, 0, 32'h2000_0000, 0, 0);
    total++;
    if (bus.WEN !== 1'b0) begin bad++; $display("FAIL zero_wen got=%0b want=0", bus.WEN); end
    tick();
    drive(1, 3, 7, 6, 0, 32'h77, 0, 0, 0, 32'h2000_0001, 0, 0);
    total++;
    if ({bus.WEN, bus.fwd_valid} !== 2'b00) begin
      bad++; $display("FAIL zero_fwd got wen=%0b fv=%0b want 0/0", bus.WEN, bus.fwd_valid);
    end
    tick();
  endtask

  task automatic test_bubbles();
    logic [31:0] base;
    base = bus.retired;
    drive(1, 1, 0, 10, 0, 32'hA, 0, 0, 0, 32'h0000_5020, 0, 0);
    tick();
    bubble();
    tick();
    total++;
    if (bus.fwd_valid !== 1'b0) begin
      bad++; $display("FAIL bubble_fwd got=%0b want=0", bus.fwd_valid);
    end
    bubble();
    tick();
    bubble();
    tick();
    drive(1, 1, 0, 11, 0, 32'hB, 0, 0, 0, 32'h0000_5820, 0, 0);
    tick();
    total++;
    if (bus.retired !== base + 32'd2) begin
      bad++; $display("FAIL bubble_count got=%0d want=%0d", bus.retired, base + 32'd2);
    end
  endtask

  task automatic test_halt();
    logic [31:0] base;
    drive(1, 1, 0, 12, 0, 32'hC, 0, 0, 0, 32'h0000_000C, 1, 0);
    total++;
    if (bus.WEN !== 1'b0) begin bad++; $display("FAIL halt_wen got=%0b want=0", bus.WEN); end
    tick();
    base = bus.retired;
    total++;
    if (bus.halted !== 1'b1) begin
      bad++; $display("FAIL halt_flag got=%0b want=1", bus.halted);
    end
    drive(1, 1, 0, 13, 0, 32'hD, 0, 0, 0, 32'h0000_6820, 0, 0);
    total++;
    if (bus.WEN !== 1'b0) begin bad++; $display("FAIL after_halt_wen got=%0b want=0", bus.WEN); end
    tick();
    total++;
    if (bus.retired !== base) begin
      bad++; $display("FAIL after_halt_count got=%0d want=%0d", bus.retired, base);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    total++;
    if ({bus.halted, bus.retired} !== 33'd0) begin
      bad++;
      $display("FAIL halt_reset got h=%0b ret=%0d want 0/0", bus.halted, bus.retired);
    end
  endtask

  task automatic test_reset_collision();
    drive(1, 1, 0, 14, 0, 32'hE, 0, 0, 0, 32'h0000_000C, 1, 1);
    tick();
    total++;
    if (bus.halted !== 1'b0) begin
      bad++; $display("FAIL collision_halted got=%0b want=0", bus.halted);
    end
    bubble();
    tick();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFD;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_0000 + i, 0, 0);
      tick();
    end
    total++;
    if (bus.retired !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL saturate got=%h want=ffffffff", bus.retired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, 16'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            $urandom_range(0, 24) == 0, $urandom_range(0, 20) == 0);
      total++;
      if ({bus.WEN, bus.wsel, bus.wdat} !== {e_wen, e_wsel, e_wdat}) begin
        bad++;
        $display("FAIL rnd_port[%0d] got %0b/%0d/%h want %0b/%0d/%h", i,
                 bus.WEN, bus.wsel, bus.wdat, e_wen, e_wsel, e_wdat);
      end
      tick();
      total++;
      if ({bus.fwd_valid, bus.fwd_reg, bus.fwd_data, bus.halted, bus.retired}
          !== {m_fv, m_fr, m_fd, m_halted, m_retired}) begin
        bad++;
        $display("FAIL rnd_state[%0d] got %0b/%0d/%h/%0b/%0d want %0b/%0d/%h/%0b/%0d", i,
                 bus.fwd_valid, bus.fwd_reg, bus.fwd_data, bus.halted, bus.retired,
                 m_fv, m_fr, m_fd, m_halted, m_retired);
      end
    end
  endtask

  initial begin
    m_halted = 0; m_retired = 0; m_fv = 0; m_fr = 0; m_fd = 0;
    test_reset();
    test_alu_write();
    test_load_lui_jal();
    test_zero_reg();
    test_bubbles();
    test_halt();
    test_reset_collision();
    test_saturation();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
